// File: rtl/i2c_target.sv
// I2C target responder: 7-bit address match, byte-wide write/read user interface, open-drain SDA.
// Optional SCL/SDA stability filter enabled by defining I2C_TARGET_GLITCH_FILT_EN.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] i_tx_byte,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_tx_req,
  output logic       o_rw,
  output logic       o_busy,
  output logic       o_start_det,
  output logic       o_stop_det
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
    $error("i2c_target: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StWaitStop
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   sda_oe_q;
  logic [6:0]             shift_q;
  logic [3:0]             bit_cnt_q;

  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILT_EN
  // Filtered value follows the raw value only after FILT_LEN consecutive differing samples.
  localparam int unsigned      CntW   = $clog2(FILT_LEN + 1);
  localparam logic [CntW-1:0]  CntMax = CntW'(FILT_LEN - 1);

  logic [1:0]      raw, filt_q;
  logic [CntW-1:0] filt_cnt_q [2];

  assign raw = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) filt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt_q[i]) begin
          filt_cnt_q[i] <= '0;
        end else if (filt_cnt_q[i] == CntMax) begin
          filt_q[i]     <= raw[i];
          filt_cnt_q[i] <= '0;
        end else begin
          filt_cnt_q[i] <= filt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign scl_s = filt_q[1];
  assign sda_s = filt_q[0];
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;

  // bit_cnt_q == 8 in StAddr/StWrData marks "byte complete, waiting for the ACK-phase fall".
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= StIdle;
      sda_oe_q    <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      o_rx_byte   <= '0;
      o_rx_valid  <= 1'b0;
      o_tx_req    <= 1'b0;
      o_rw        <= 1'b0;
      o_busy      <= 1'b0;
      o_start_det <= 1'b0;
      o_stop_det  <= 1'b0;
    end else begin
      o_rx_valid  <= 1'b0;
      o_tx_req    <= 1'b0;
      o_start_det <= 1'b0;
      o_stop_det  <= 1'b0;
      if (start_cond) begin
        state_q     <= StAddr;
        bit_cnt_q   <= '0;
        sda_oe_q    <= 1'b0;
        o_busy      <= 1'b0;
        o_start_det <= 1'b1;
      end else if (stop_cond) begin
        state_q    <= StIdle;
        bit_cnt_q  <= '0;
        sda_oe_q   <= 1'b0;
        o_busy     <= 1'b0;
        o_stop_det <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle, StWaitStop: ;
          StAddr: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              shift_q   <= {shift_q[5:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (shift_q == TARGET_ADDR) o_rw <= sda_s;
                else                        state_q <= StWaitStop;
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              sda_oe_q <= 1'b1;
              o_busy   <= 1'b1;
              state_q  <= StAddrAck;
            end
          end
          StAddrAck: begin
            if (scl_rise) begin
              o_tx_req <= o_rw;
            end else if (scl_fall) begin
              bit_cnt_q <= '0;
              if (o_rw) begin
                shift_q  <= i_tx_byte[6:0];
                sda_oe_q <= ~i_tx_byte[7];
                state_q  <= StRdData;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= StWrData;
              end
            end
          end
          StWrData: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              shift_q   <= {shift_q[5:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                o_rx_byte  <= {shift_q, sda_s};
                o_rx_valid <= 1'b1;
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              sda_oe_q <= 1'b1;
              state_q  <= StWrAck;
            end
          end
          StWrAck: begin
            if (scl_fall) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= StWrData;
            end
          end
          StRdData: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd7) begin
                sda_oe_q <= 1'b0;
                state_q  <= StRdAck;
              end else begin
                sda_oe_q  <= ~shift_q[6];
                shift_q   <= {shift_q[5:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              if (!sda_s) begin
                o_tx_req <= 1'b1;
              end else begin
                o_busy  <= 1'b0;
                state_q <= StWaitStop;
              end
            end else if (scl_fall) begin
              shift_q   <= i_tx_byte[6:0];
              sda_oe_q  <= ~i_tx_byte[7];
              bit_cnt_q <= '0;
              state_q   <= StRdData;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboarded bench for i2c_target: bus tasks act as the I2C controller, a monitor checks pulses.
module tb_i2c_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       scl;
  logic       sda_low;
  wire        sda;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       rx_valid, tx_req, rw, busy, start_det, stop_det;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target #(
    .TARGET_ADDR(7'h50),
    .SYNC_STAGES(2),
    .FILT_LEN   (4)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i2c_scl    (scl),
    .i2c_sda    (sda),
    .i_tx_byte  (tx_byte),
    .o_rx_byte  (rx_byte),
    .o_rx_valid (rx_valid),
    .o_tx_req   (tx_req),
    .o_rw       (rw),
    .o_busy     (busy),
    .o_start_det(start_det),
    .o_stop_det (stop_det)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Event kinds: 1 start, 2 stop, 3 rx byte, 4 tx request (data = o_rw).
  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  task automatic expect_ev(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int k, input logic [7:0] d);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got kind %0d data %02h, want no event", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d) begin
        n_bad++;
        $display("FAIL sb_event: got kind %0d data %02h, want kind %0d data %02h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (start_det) sb_pop(1, 8'h00);
    if (stop_det)  sb_pop(2, 8'h00);
    if (rx_valid)  sb_pop(3, rx_byte);
    if (tx_req)    sb_pop(4, {7'b0, rw});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b0; tick(Q);
    scl = 1'b1;     tick(Q);
    sda_low = 1'b1; tick(Q);
    scl = 1'b0;     tick(Q);
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; tick(Q);
    scl = 1'b1;     tick(Q);
    sda_low = 1'b0; tick(2 * Q);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_low = ~b; tick(Q);
    scl = 1'b1;   tick(Q);
    @(negedge clk);
    r = sda;
    tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic bus_wr(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(v[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic bus_rd(output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      v[i] = r;
    end
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] v;
    logic [7:0] addr_w;

    rstn = 1'b0; scl = 1'b1; sda_low = 1'b0; tx_byte = 8'h00;
    tick(3);
    @(negedge clk);
    check("reset_outs", {rx_byte, rx_valid, tx_req, rw, busy, start_det, stop_det}, 0);
    check("reset_sda", sda, 1);
    rstn = 1'b1;
    tick(5);

    // Write 0x50 + 0xA5
    expect_ev(1, 8'h00);
    bus_start();
    bus_wr(8'hA0, ack);
    check("wr_addr_ack", ack, 0);
    @(negedge clk);
    check("wr_rw", rw, 0);
    check("wr_busy", busy, 1);
    expect_ev(3, 8'hA5);
    bus_wr(8'hA5, ack);
    check("wr_data_ack", ack, 0);
    check("wr_rx_byte", rx_byte, 8'hA5);
    expect_ev(2, 8'h00);
    bus_stop();
    @(negedge clk);
    check("wr_busy_end", busy, 0);

    // Wrong address 0x51
    expect_ev(1, 8'h00);
    bus_start();
    bus_wr(8'hA2, ack);
    check("nomatch_ack", ack, 1);
    bus_wr(8'h00, ack);
    check("nomatch_data_ack", ack, 1);
    @(negedge clk);
    check("nomatch_busy", busy, 0);
    expect_ev(2, 8'h00);
    bus_stop();

    // Read 0x3C (ACK) then 0xC3 (NACK)
    tx_byte = 8'h3C;
    expect_ev(1, 8'h00);
    bus_start();
    expect_ev(4, 8'h01);
    bus_wr(8'hA1, ack);
    check("rd_addr_ack", ack, 0);
    @(negedge clk);
    check("rd_rw", rw, 1);
    bus_rd(v);
    check("rd_byte0", v, 8'h3C);
    tx_byte = 8'hC3;
    expect_ev(4, 8'h01);
    bus_bit(1'b0, r);
    bus_rd(v);
    check("rd_byte1", v, 8'hC3);
    bus_bit(1'b1, r);
    check("rd_nack_seen", r, 1);
    @(negedge clk);
    check("rd_sda_released", sda, 1);
    check("rd_busy_after_nack", busy, 0);
    expect_ev(2, 8'h00);
    bus_stop();

    // Write 0x12, repeated START, read 0x7E
    expect_ev(1, 8'h00);
    bus_start();
    bus_wr(8'hA0, ack);
    check("rs_wr_ack", ack, 0);
    @(negedge clk);
    check("rs_rw0", rw, 0);
    expect_ev(3, 8'h12);
    bus_wr(8'h12, ack);
    check("rs_data_ack", ack, 0);
    check("rs_rx_byte", rx_byte, 8'h12);
    tx_byte = 8'h7E;
    expect_ev(1, 8'h00);
    bus_start();
    expect_ev(4, 8'h01);
    bus_wr(8'hA1, ack);
    check("rs_rd_ack", ack, 0);
    @(negedge clk);
    check("rs_rw1", rw, 1);
    bus_rd(v);
    check("rs_rd_byte", v, 8'h7E);
    bus_bit(1'b1, r);
    expect_ev(2, 8'h00);
    bus_stop();

    // Reset while the target drives the address ACK
    addr_w = 8'hA0;
    expect_ev(1, 8'h00);
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(addr_w[i], r);
    sda_low = 1'b0;
    tick(2);
    @(negedge clk);
    check("mid_ack_driven", sda, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_sda", sda, 1);
    check("mid_rst_outs", {rx_byte, rx_valid, tx_req, rw, busy, start_det, stop_det}, 0);
    tick(3);
    rstn = 1'b1;
    tick(5);
    expect_ev(1, 8'h00);
    bus_start();
    bus_wr(8'hA0, ack);
    check("post_rst_ack", ack, 0);
    expect_ev(2, 8'h00);
    bus_stop();

`ifdef I2C_TARGET_GLITCH_FILT_EN
    // Short SDA spike with SCL high is filtered; a longer one is a START then a STOP
    tick(10);
    sda_low = 1'b1; tick(2);
    sda_low = 1'b0; tick(20);
    expect_ev(1, 8'h00);
    expect_ev(2, 8'h00);
    sda_low = 1'b1; tick(6);
    sda_low = 1'b0; tick(20);
`endif

    tick(20);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
